// File: rtl/serial_parity_engine_pkg.sv
// parity_pkg: shared types, mode constants and sizing helper for the serial parity engine
package parity_pkg;

    typedef enum logic {
        PAR_IDLE,
        PAR_ACCUM
    } par_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Counter must reach DATA_BITS+1 (check mode frame length) without wrapping.
    function automatic int par_cnt_w(input int data_bits);
        return $clog2(data_bits + 2);
    endfunction

endpackage

// File: rtl/serial_parity_engine_if.sv
// serial_parity_engine_if: frame-bit input and parity/status output bundle
interface serial_parity_engine_if #(
    parameter int ERR_CNT_W = 8
);

    logic                 i_valid;
    logic                 i_x;
    logic                 i_odd;
    logic                 i_check_en;
    logic                 i_abort;
    logic                 i_err_clr;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_parity;
    logic                 o_err;
    logic [ERR_CNT_W-1:0] o_err_cnt;

    modport master (
        output i_valid, i_x, i_odd, i_check_en, i_abort, i_err_clr,
        input  o_busy, o_done, o_parity, o_err, o_err_cnt
    );

    modport slave (
        input  i_valid, i_x, i_odd, i_check_en, i_abort, i_err_clr,
        output o_busy, o_done, o_parity, o_err, o_err_cnt
    );

endinterface

// File: rtl/serial_parity_engine_err_counter.sv
// parity_err_counter: saturating error event counter, clear beats increment
module parity_err_counter #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_inc,
    input  logic                 i_clr,
    output logic [ERR_CNT_W-1:0] o_cnt
);

    // Count error events, stick at all-ones until cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            o_cnt <= '0;
        else if (i_clr)
            o_cnt <= '0;
        else if (i_inc && o_cnt != '1)
            o_cnt <= o_cnt + 1'b1;
    end

endmodule

// File: rtl/serial_parity_engine.sv
// serial_parity_engine: bit-serial even/odd parity generator and checker with error counter
module serial_parity_engine
    import parity_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int ERR_CNT_W = 8
) (
    input logic clk,
    input logic reset,
    serial_parity_engine_if.slave bus
);

    localparam int CW = par_cnt_w(DATA_BITS);

    par_state_t    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          acc;
    logic          odd_l;
    logic          chk_l;
    logic          busy;
    logic          done;
    logic          parity;
    logic          err;
    logic          first;
    logic          odd_m;
    logic          chk_m;
    logic          is_data;
    logic          last;
    logic          acc_n;
    logic          par_n;
    logic          err_n;
    logic          accept;

    // The first bit of a frame takes its mode straight from the inputs; later bits use the latched mode.
    assign first   = state == PAR_IDLE;
    assign odd_m   = first ? bus.i_odd : odd_l;
    assign chk_m   = first ? bus.i_check_en : chk_l;
    assign cnt_n   = cnt + 1'b1;
    assign is_data = cnt < CW'(DATA_BITS);
    assign last    = cnt_n == CW'(DATA_BITS) + CW'(chk_m);
    assign acc_n   = (first ? 1'b0 : acc) ^ (is_data & bus.i_x);
    assign par_n   = acc_n ^ odd_m;
    assign err_n   = chk_m & (bus.i_x != par_n);
    assign accept  = bus.i_valid & ~bus.i_abort;

    // Frame FSM: accumulate bits, on the last bit publish parity/error and return to idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= PAR_IDLE;
            cnt    <= '0;
            acc    <= 1'b0;
            odd_l  <= PAR_EVEN;
            chk_l  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            parity <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (bus.i_abort) begin
                state <= PAR_IDLE;
                cnt   <= '0;
                acc   <= 1'b0;
                busy  <= 1'b0;
            end else if (bus.i_valid) begin
                if (first) begin
                    odd_l <= odd_m;
                    chk_l <= chk_m;
                end
                if (last) begin
                    state  <= PAR_IDLE;
                    cnt    <= '0;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    parity <= par_n;
                    err    <= err_n;
                end else begin
                    state <= PAR_ACCUM;
                    cnt   <= cnt_n;
                    acc   <= acc_n;
                    busy  <= 1'b1;
                end
            end
        end
    end

    assign bus.o_busy   = busy;
    assign bus.o_done   = done;
    assign bus.o_parity = parity;
    assign bus.o_err    = err;

    parity_err_counter #(
        .ERR_CNT_W(ERR_CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .i_inc (accept & last & err_n),
        .i_clr (bus.i_err_clr),
        .o_cnt (bus.o_err_cnt)
    );

endmodule

// File: tb/tb_serial_parity_engine.sv
// tb_serial_parity_engine: three engine configurations driven in lockstep against a frame-level model
module tb_serial_parity_engine;

    logic clk;
    logic reset;
    logic valid;
    logic x;
    logic odd;
    logic chk_en;
    logic abort;
    logic clr;

    logic        ob [3];
    logic        od [3];
    logic        op [3];
    logic        oe [3];
    logic [31:0] oc [3];

    int dbs [3] = '{8, 8, 1};
    int ws  [3] = '{8, 2, 8};

    int m_n [3];
    int m_ones [3];
    int m_cnt [3];
    bit m_lo [3];
    bit m_lc [3];
    bit m_busy [3];
    bit m_done [3];
    bit m_par [3];
    bit m_err [3];

    int n_cmp = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int DB = g == 2 ? 1 : 8;
        localparam int W  = g == 1 ? 2 : 8;
        serial_parity_engine_if #(.ERR_CNT_W(W)) bus ();
        assign bus.i_valid    = valid;
        assign bus.i_x        = x;
        assign bus.i_odd      = odd;
        assign bus.i_check_en = chk_en;
        assign bus.i_abort    = abort;
        assign bus.i_err_clr  = clr;
        assign ob[g] = bus.o_busy;
        assign od[g] = bus.o_done;
        assign op[g] = bus.o_parity;
        assign oe[g] = bus.o_err;
        assign oc[g] = 32'(bus.o_err_cnt);
        serial_parity_engine #(.DATA_BITS(DB), .ERR_CNT_W(W)) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_n[k] = 0; m_ones[k] = 0; m_cnt[k] = 0; m_lo[k] = 0; m_lc[k] = 0;
            m_busy[k] = 0; m_done[k] = 0; m_par[k] = 0; m_err[k] = 0;
        end
    endtask

    // Frame-level reference: counts bits and ones, parity from the ones count.
    task automatic model_step(input int k);
        int len;
        int sat;
        m_done[k] = 0;
        if (abort) begin
            m_n[k] = 0;
            m_ones[k] = 0;
        end else if (valid) begin
            if (m_n[k] == 0) begin
                m_lo[k] = odd;
                m_lc[k] = chk_en;
            end
            len = dbs[k] + int'(m_lc[k]);
            if (m_n[k] < dbs[k]) m_ones[k] += int'(x);
            m_n[k]++;
            if (m_n[k] == len) begin
                m_done[k] = 1;
                m_par[k] = ((m_ones[k] % 2) == 1) ^ m_lo[k];
                m_err[k] = m_lc[k] && (x != m_par[k]);
                m_n[k] = 0;
                m_ones[k] = 0;
                sat = (1 << ws[k]) - 1;
                if (m_err[k] && m_cnt[k] < sat) m_cnt[k]++;
            end
        end
        if (clr) m_cnt[k] = 0;
        m_busy[k] = m_n[k] != 0;
    endtask

    task automatic cmp_all(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_d%0d_busy", tag, k), 32'(ob[k]), 32'(m_busy[k]));
            chk($sformatf("%s_d%0d_done", tag, k), 32'(od[k]), 32'(m_done[k]));
            chk($sformatf("%s_d%0d_par", tag, k), 32'(op[k]), 32'(m_par[k]));
            chk($sformatf("%s_d%0d_err", tag, k), 32'(oe[k]), 32'(m_err[k]));
            chk($sformatf("%s_d%0d_cnt", tag, k), oc[k], 32'(m_cnt[k]));
        end
    endtask

    task automatic step(input logic v, input logic xb, input logic o, input logic c,
                        input logic a, input logic cl);
        valid = v; x = xb; odd = o; chk_en = c; abort = a; clr = cl;
        for (int k = 0; k < 3; k++) model_step(k);
        @(posedge clk);
        #1;
        cmp_all("cyc");
    endtask

    task automatic frame(input logic [63:0] bits, input int nb, input logic o, input logic c,
                         input int gap, input logic clr_last);
        for (int i = 0; i < nb; i++) begin
            if (i > 0) repeat (gap) step(0, 0, 0, 0, 0, 0);
            step(1, bits[i], o, c, 0, clr_last && i == nb - 1);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0);
    endtask

    int exp_sat [5] = '{1, 2, 3, 3, 3};

    initial begin
        reset = 1'b1;
        valid = 0; x = 0; odd = 0; chk_en = 0; abort = 0; clr = 0;
        model_reset();
        #1;
        cmp_all("rst");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);

        frame(64'b0000_1101, 8, 0, 0, 0, 0);
        chk("even_done", 32'(od[0]), 1);
        chk("even_par", 32'(op[0]), 1);
        chk("even_err", 32'(oe[0]), 0);
        idle(2);

        frame(64'b0000_1101, 8, 1, 0, 2, 0);
        chk("odd_gap_par", 32'(op[0]), 0);
        chk("odd_gap_done", 32'(od[0]), 1);
        idle(2);

        frame(64'b0_1111_1111, 9, 0, 1, 0, 0);
        chk("chk_ok_par", 32'(op[0]), 0);
        chk("chk_ok_err", 32'(oe[0]), 0);
        frame(64'b0_0000_0001, 9, 0, 1, 0, 0);
        chk("chk_bad_err", 32'(oe[0]), 1);
        chk("chk_bad_cnt", oc[0], 1);
        idle(2);

        frame(64'b1_0110, 5, 0, 0, 0, 0);
        step(1, 1, 0, 0, 1, 0);
        chk("abort_busy", 32'(ob[0]), 0);
        frame(64'b0000_0011, 8, 0, 0, 0, 0);
        chk("abort_par", 32'(op[0]), 0);
        chk("abort_cnt", oc[0], 1);
        idle(2);

        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            frame(64'b0_0000_0001, 9, 0, 1, 0, 0);
            chk($sformatf("sat_%0d", i), oc[1], 32'(exp_sat[i]));
        end
        frame(64'b0_0000_0001, 9, 0, 1, 0, 1);
        chk("sat_clr", oc[1], 0);
        idle(2);

        step(1, 1, 0, 0, 0, 0);
        chk("db1_done", 32'(od[2]), 1);
        chk("db1_par", 32'(op[2]), 1);

        frame(64'b101, 3, 1, 1, 0, 0);
        #2 reset = 1'b1;
        #1;
        model_reset();
        cmp_all("async_rst");
        #1 reset = 1'b0;
        idle(2);

        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_parity_engine.md
# serial_parity_engine

Parametrised serial parity engine for bit-serial links: accumulates a frame of `DATA_BITS` bits presented one per qualified cycle and emits even or odd parity. In check mode it also consumes the trailing received parity bit and flags mismatches. A saturating error counter is included for link monitoring. It is the generalised successor of the fixed 3-bit even-parity FSM and sits between the serial deserialiser and the link-status registers.

## Interface
- `DATA_BITS`, 8: data bits per frame; legal 1..64.
- `ERR_CNT_W`, 8: width of the saturating error counter; legal 1..32.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high; clock is `clk`.
- `i_valid` in 1: `i_x` is a frame bit this cycle.
- `i_x` in 1: serial bit; first bit of frame first.
- `i_odd` in 1: 1 = odd parity, 0 = even; sampled with the first bit of a frame.
- `i_check_en` in 1: 1 = check mode (frame = `DATA_BITS`+1 bits, last bit is received parity); sampled with the first bit.
- `i_abort` in 1: synchronous discard of the partial frame.
- `i_err_clr` in 1: synchronous clear of `o_err_cnt`.
- `o_busy` out 1: frame in progress (≥1 bit accepted, frame not complete).
- `o_done` out 1: one-cycle pulse, frame complete; `o_parity`/`o_err` valid.
- `o_parity` out 1: computed parity of the data bits of the last completed frame.
- `o_err` out 1: check mode only: received parity ≠ computed parity; 0 in generate mode.
- `o_err_cnt` out `ERR_CNT_W`: count of `o_err` events, saturating at all-ones.

## Operation
- States: IDLE (no bits held) and ACCUM (1..L-1 bits held), with L = `DATA_BITS` + `check`.
- Bit counter width is clog2(`DATA_BITS`+2). Accumulator is a single XOR bit.
- IDLE with `i_valid`:
  - latch `i_odd` and `i_check_en`;
  - acc = `i_x`, cnt = 1;
  - go to ACCUM, unless L = 1, in which case the frame completes this cycle.
- ACCUM with `i_valid`:
  - data bits (cnt < `DATA_BITS`): acc ^= `i_x`;
  - the parity bit (cnt = `DATA_BITS`, check mode) is not folded into acc;
  - cnt++.
- Completion, on acceptance of bit L:
  - parity = acc(data) ^ odd_latched;
  - err = check_latched & (`i_x` ≠ parity);
  - return to IDLE.
- Even mode: parity = 1 when the data holds an odd number of ones, so data plus parity has an even count. Odd mode inverts this.
- Cycles without `i_valid` hold all state; gaps inside a frame are legal.
- Mode inputs are ignored after the first bit of a frame.
- `i_abort`:
  - return to IDLE, cnt = 0, no `o_done`;
  - `o_parity`, `o_err` and `o_err_cnt` are unchanged;
  - it has priority over `i_valid` in the same cycle, and that bit is dropped.
- `o_err_cnt` increments on every `o_done` with err = 1 and holds at 2^`ERR_CNT_W`-1.
- When `i_err_clr` and an increment coincide, the clear wins and the result is 0.

## Timing
- Reset values: state IDLE, cnt 0; `o_busy` 0, `o_done` 0, `o_parity` 0, `o_err` 0, `o_err_cnt` 0.
- All outputs are registered.
- `o_done`, `o_parity` and `o_err` update in the cycle after the last bit is accepted (latency 1).
- `o_parity` and `o_err` hold until the next `o_done`.
- `o_busy` rises the cycle after the first accepted bit and falls the cycle after the last bit, coincident with `o_done`.
- Back-to-back frames are legal with no bubble: a valid bit in the cycle `o_done` is high is the first bit of the next frame.
- `o_err_cnt` updates in the same cycle as `o_done`.
- Reset mid-frame discards everything immediately (asynchronous).

## Structure
- Package `parity_pkg`:
  - state enum `PAR_IDLE`/`PAR_ACCUM`;
  - mode constants `PAR_EVEN`=0, `PAR_ODD`=1;
  - function `par_cnt_w(DATA_BITS)` returning the bit-counter width.
- Sub-module `parity_err_counter`:
  - parameter `ERR_CNT_W`;
  - inputs `clk`, `reset`, `i_inc`, `i_clr`;
  - output `o_cnt`;
  - saturating, clear-over-increment.
- The top holds the FSM, bit counter, accumulator and output registers.

## Test plan
- Even generate, `DATA_BITS`=8, bits 1,0,1,1,0,0,0,0 (three ones), contiguous valid → `o_done` 1 cycle after the 8th bit, `o_parity`=1, `o_err`=0, `o_err_cnt`=0.
- Odd generate, same data with `i_valid` gaps of 2 cycles between bits → `o_parity`=0, `o_busy` high throughout, single `o_done` pulse.
- Check mode, even:
  - data 0xFF then parity bit 0 → `o_parity`=0, `o_err`=0;
  - next frame back-to-back, data 0x01 then parity bit 0 → `o_err`=1, `o_err_cnt`=1, no idle cycle between frames.
- `i_abort` after 5 bits, then a new 8-bit frame of 0x03 in even mode → exactly one `o_done`, `o_parity`=0. `o_err_cnt` is unchanged across the abort.
- `ERR_CNT_W`=2, five consecutive error frames → `o_err_cnt` sequence 1,2,3,3,3. `i_err_clr` asserted with a 6th error frame's `o_done` → 0.
- `DATA_BITS`=1, generate mode, bit 1 → `o_done` next cycle, `o_parity`=1. Reset asserted mid-frame at `DATA_BITS`=8 → all outputs 0 immediately, `o_busy`=0.
